// File: rtl/clock_mon_pkg.sv
// Shared definitions for the clock frequency monitor.
//   state_e   : monitor FSM state encoding (also exported on the debug port)
//   cnt_width : bits needed to hold the values 0..max_val
package clock_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous clock-like signal into the clk_i domain and emits a
// one-cycle pulse for every rising transition.
//   clk_i   : sampling clock
//   rst_i   : synchronous active-high reset, clears every flop
//   async_i : asynchronous input
//   edge_o  : registered rising-edge pulse
// A 0->1 transition sampled by the first flop on edge k appears on edge_o
// after edge k+2, so logic clocked by clk_i consumes it on edge k+3.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/clock_freq_monitor.sv
// Measures a monitored clock against a trusted clock by counting its rising
// edges over fixed windows, tracks lock with hysteresis and detects stalls.
//   clk_pi/rst_pi  : trusted clock, synchronous active-high reset
//   en_pi          : enable; low forces IDLE and clears the window machinery
//   mon_pi         : monitored clock (asynchronous)
//   clear_pi       : clears the sticky error flag
//   edge_count_po  : edge count of the last completed window
//   count_valid_po : one-cycle pulse, high in the cycle edge_count_po and
//                    in_range_po take a new window's result; there is no
//                    back-pressure, a consumer must sample it in that cycle
//   in_range_po    : last window within EXPECTED_EDGES +/- TOLERANCE
//   locked_po      : FSM in LOCKED
//   stalled_po     : no monitored edge for STALL_CYCLES or more cycles
//   error_po       : sticky, set on LOCKED->LOST
//   state_po       : debug view of the FSM state
module clock_freq_monitor
  import clock_mon_pkg::*;
#(
  parameter int  WINDOW_CYCLES  = 1024,
  parameter int  EXPECTED_EDGES = 256,
  parameter int  TOLERANCE      = 4,
  parameter int  LOCK_WINDOWS   = 3,
  parameter int  UNLOCK_WINDOWS = 2,
  parameter int  STALL_CYCLES   = 64,
  localparam int CNT_W          = cnt_width(WINDOW_CYCLES)
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             en_pi,
  input  logic             mon_pi,
  input  logic             clear_pi,
  output logic [CNT_W-1:0] edge_count_po,
  output logic             count_valid_po,
  output logic             in_range_po,
  output logic             locked_po,
  output logic             stalled_po,
  output logic             error_po,
  output state_e           state_po
);

  localparam int WIN_W   = cnt_width(WINDOW_CYCLES - 1);
  localparam int STALL_W = cnt_width(STALL_CYCLES);
  localparam int GOOD_W  = cnt_width(LOCK_WINDOWS);
  localparam int BAD_W   = cnt_width(UNLOCK_WINDOWS);
  localparam int LO_INT  = (EXPECTED_EDGES > TOLERANCE) ? (EXPECTED_EDGES - TOLERANCE) : 0;

  localparam logic [31:0]        LO_BOUND  = 32'(LO_INT);
  localparam logic [31:0]        HI_BOUND  = 32'(EXPECTED_EDGES + TOLERANCE);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYCLES);
  localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(LOCK_WINDOWS - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST  = BAD_W'(UNLOCK_WINDOWS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic               edge_pulse;
  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [CNT_W-1:0]   edge_count_q;
  logic               count_valid_q;
  logic               in_range_q;
  logic               error_q, error_d;

  logic               term;
  logic [CNT_W-1:0]   closing_cnt;
  logic               win_in_range;
  logic               stall_rise;
  logic               err_set;

  sync_edge_detect u_sync_edge (
    .clk_i   (clk_pi),
    .rst_i   (rst_pi),
    .async_i (mon_pi),
    .edge_o  (edge_pulse)
  );

  assign term = en_pi && (win_q == WIN_LAST);

  // Datapath: window/edge/stall counters. closing_cnt already includes an
  // edge arriving on the terminal cycle so that edge lands in the closing
  // window and the next window restarts from zero.
  always_comb begin
    win_d       = win_q;
    edge_cnt_d  = edge_cnt_q;
    stall_d     = stall_q;
    closing_cnt = edge_cnt_q;
    if (edge_pulse && (edge_cnt_q != CNT_MAX)) begin
      closing_cnt = edge_cnt_q + 1'b1;
    end
    if (!en_pi) begin
      win_d      = '0;
      edge_cnt_d = '0;
      stall_d    = '0;
    end else begin
      win_d      = term ? '0 : win_q + 1'b1;
      edge_cnt_d = term ? '0 : closing_cnt;
      if (edge_pulse) begin
        stall_d = '0;
      end else if (stall_q < STALL_LIM) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  assign win_in_range = (32'(closing_cnt) >= LO_BOUND) && (32'(closing_cnt) <= HI_BOUND);
  // Stall is acted on in the same edge that raises stalled_po, so lock drops
  // and the error sets together with it.
  assign stall_rise   = (stall_d >= STALL_LIM) && (stall_q < STALL_LIM);

  // FSM next state and good/bad window counters.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_set = 1'b0;
    if (!en_pi) begin
      state_d = ST_IDLE;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (term) begin
            if (!win_in_range) begin
              good_d = '0;
            end else if (good_q >= GOOD_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (stall_rise) begin
            state_d = ST_LOST;
            bad_d   = '0;
            err_set = 1'b1;
          end else if (term) begin
            if (win_in_range) begin
              bad_d = '0;
            end else if (bad_q >= BAD_LAST) begin
              state_d = ST_LOST;
              bad_d   = '0;
              err_set = 1'b1;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
        ST_LOST: begin
          // The recovering window already counts as the first good one.
          if (term && win_in_range) begin
            state_d = ST_ACQUIRE;
            good_d  = GOOD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A new error wins over a simultaneous clear.
  assign error_d = err_set | (error_q & ~clear_pi);

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_q       <= ST_IDLE;
      win_q         <= '0;
      edge_cnt_q    <= '0;
      stall_q       <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      edge_cnt_q    <= edge_cnt_d;
      stall_q       <= stall_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      count_valid_q <= term;
      if (term) begin
        edge_count_q <= closing_cnt;
        in_range_q   <= win_in_range;
      end
      error_q       <= error_d;
    end
  end

  assign edge_count_po  = edge_count_q;
  assign count_valid_po = count_valid_q;
  assign in_range_po    = in_range_q;
  assign locked_po      = (state_q == ST_LOCKED);
  assign stalled_po     = (stall_q >= STALL_LIM);
  assign error_po       = error_q;
  assign state_po       = state_q;

endmodule

// File: tb/tb_clock_freq_monitor.sv
// Bench for clock_freq_monitor at default parameters: randomized monitored
// clock waveforms, a cycle-level reference model driven by the spec rules,
// a window-count scoreboard and directed scenario checks.
module tb_clock_freq_monitor;
  import clock_mon_pkg::*;

  localparam int WIN      = 1024;
  localparam int EXP      = 256;
  localparam int TOL      = 4;
  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 2;
  localparam int STALL    = 64;
  localparam int CNT_W    = $clog2(WIN + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam int MON_LOW   = 0;
  localparam int MON_25    = 1;
  localparam int MON_27    = 2;
  localparam int MON_PULSE = 3;

  // clock / reset / inputs
  logic             clk_pi = 1'b0;
  logic             rst_pi = 1'b1;
  logic             en_pi = 1'b0;
  logic             mon_pi;
  logic             clear_pi = 1'b0;
  logic [CNT_W-1:0] edge_count_po;
  logic             count_valid_po;
  logic             in_range_po;
  logic             locked_po;
  logic             stalled_po;
  logic             error_po;
  state_e           state_po;

  int mon_mode  = MON_25;
  bit pulse_arm = 1'b0;
  bit chk_on    = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit               pipe [3];
  bit               m_prev  = 1'b0;
  int               m_win   = 0;
  int               m_cnt   = 0;
  int               m_stall = 0;
  int               m_good  = 0;
  int               m_bad   = 0;
  state_e           m_state = ST_IDLE;
  bit               m_err   = 1'b0;
  logic [CNT_W-1:0] m_count = '0;
  bit               m_valid = 1'b0;
  bit               m_inr   = 1'b0;
  logic [CNT_W-1:0] exp_q[$];

  clock_freq_monitor dut (
    .clk_pi         (clk_pi),
    .rst_pi         (rst_pi),
    .en_pi          (en_pi),
    .mon_pi         (mon_pi),
    .clear_pi       (clear_pi),
    .edge_count_po  (edge_count_po),
    .count_valid_po (count_valid_po),
    .in_range_po    (in_range_po),
    .locked_po      (locked_po),
    .stalled_po     (stalled_po),
    .error_po       (error_po),
    .state_po       (state_po)
  );

  initial forever #5 clk_pi = ~clk_pi;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitored clock generator. Rising edges are periodic; duty cycle is random.
  initial begin
    int p;
    int hi;
    mon_pi = 1'b0;
    forever begin
      if (mon_mode == MON_25 || mon_mode == MON_27) begin
        p  = (mon_mode == MON_27 && $urandom_range(0, 9) < 3) ? 3 : 4;
        hi = $urandom_range(1, p - 1);
        @(negedge clk_pi);
        mon_pi = 1'b1;
        repeat (hi - 1) @(negedge clk_pi);
        @(negedge clk_pi);
        mon_pi = 1'b0;
        repeat (p - hi - 1) @(negedge clk_pi);
      end else begin
        @(negedge clk_pi);
        // Pulse sampled at window cycle WIN-4 reaches the counter on the terminal cycle.
        mon_pi = (mon_mode == MON_PULSE) && pulse_arm && (m_win == WIN - 4 || m_win == WIN - 3);
      end
    end
  end

  // Reference model: an edge sampled at clock k is counted at clock k+3.
  initial begin
    bit e;
    bit done;
    bit rise;
    bit was_stalled;
    bit set_err;
    forever begin
      @(posedge clk_pi);
      if (rst_pi) begin
        pipe = '{1'b0, 1'b0, 1'b0};
        m_prev = 0; m_win = 0; m_cnt = 0; m_stall = 0; m_good = 0; m_bad = 0;
        m_state = ST_IDLE; m_err = 0; m_count = '0; m_valid = 0; m_inr = 0;
        exp_q.delete();
      end else begin
        e = pipe[0];
        pipe[0] = pipe[1];
        pipe[1] = pipe[2];
        pipe[2] = mon_pi & ~m_prev;
        m_prev  = mon_pi;
        m_valid = 0;
        set_err = 0;
        if (!en_pi) begin
          m_state = ST_IDLE;
          m_win = 0; m_cnt = 0; m_good = 0; m_bad = 0; m_stall = 0;
        end else begin
          was_stalled = (m_stall >= STALL);
          if (e) m_stall = 0;
          else if (m_stall < STALL) m_stall++;
          rise = !was_stalled && (m_stall >= STALL);
          if (e && m_cnt < CNT_MAX) m_cnt++;
          done  = (m_win == WIN - 1);
          m_win = done ? 0 : m_win + 1;
          if (done) begin
            m_count = CNT_W'(m_cnt);
            m_inr   = (m_cnt >= EXP - TOL) && (m_cnt <= EXP + TOL);
            m_valid = 1;
            exp_q.push_back(CNT_W'(m_cnt));
            m_cnt = 0;
          end
          case (m_state)
            ST_IDLE: m_state = ST_ACQUIRE;
            ST_ACQUIRE: if (done) begin
              if (m_inr) begin
                m_good++;
                if (m_good >= LOCK_N) begin m_state = ST_LOCKED; m_good = 0; m_bad = 0; end
              end else m_good = 0;
            end
            ST_LOCKED: if (rise) begin
              m_state = ST_LOST; m_bad = 0; set_err = 1;
            end else if (done) begin
              if (!m_inr) begin
                m_bad++;
                if (m_bad >= UNLOCK_N) begin m_state = ST_LOST; m_bad = 0; set_err = 1; end
              end else m_bad = 0;
            end
            ST_LOST: if (done && m_inr) begin m_state = ST_ACQUIRE; m_good = 1; end
            default: ;
          endcase
        end
        if (set_err) m_err = 1;
        else if (clear_pi) m_err = 0;
      end
    end
  end

  // Scoreboard and cycle checker, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_pi);
      if (chk_on) begin
        check_eq("cycle_outputs",
                 {edge_count_po, count_valid_po, in_range_po, locked_po, stalled_po, error_po, state_po},
                 {m_count, m_valid, m_inr, m_state == ST_LOCKED, m_stall >= STALL, m_err, m_state});
        if (count_valid_po) begin
          check_eq("sb_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) check_eq("sb_count", edge_count_po, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk_pi);
      n++;
    end while (!count_valid_po && n < 4096);
    check_eq(tag, count_valid_po, 1'b1);
  endtask

  task automatic wait_win(input int target, input string tag);
    int n = 0;
    while (m_win != target && n < 4096) begin
      @(negedge clk_pi);
      n++;
    end
    check_eq(tag, n < 4096, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_count"},   edge_count_po, 0);
    check_eq({tag, "_valid"},   count_valid_po, 0);
    check_eq({tag, "_inrange"}, in_range_po, 0);
    check_eq({tag, "_locked"},  locked_po, 0);
    check_eq({tag, "_stalled"}, stalled_po, 0);
    check_eq({tag, "_error"},   error_po, 0);
  endtask

  initial begin
    int n;
    // reset
    repeat (3) @(negedge clk_pi);
    check_all_zero("rst");
    chk_on = 1'b1;
    rst_pi = 1'b0;
    en_pi  = 1'b1;

    // nominal 25 MHz: lock at the end of window 3
    for (int w = 1; w <= 3; w++) begin
      wait_valid("w25_valid");
      check_eq("w25_range", (edge_count_po >= 255) && (edge_count_po <= 257), 1'b1);
      check_eq("w25_inrange", in_range_po, 1'b1);
      check_eq("w25_locked", locked_po, w == 3);
    end

    // ~27 MHz: two bad windows drop lock and raise error
    mon_mode = MON_27;
    wait_valid("w27_valid1");
    check_eq("w27_inrange1", in_range_po, 1'b0);
    check_eq("w27_locked1", locked_po, 1'b1);
    wait_valid("w27_valid2");
    check_eq("w27_locked2", locked_po, 1'b0);
    check_eq("w27_error", error_po, 1'b1);

    // clear the sticky error
    clear_pi = 1'b1;
    @(negedge clk_pi);
    clear_pi = 1'b0;
    check_eq("err_clear", error_po, 1'b0);

    // relock
    mon_mode = MON_25;
    repeat (5) wait_valid("relock_valid");
    check_eq("relock", locked_po, 1'b1);

    // stall while locked, with a clear on the same cycle as the new error
    mon_mode = MON_LOW;
    n = 0;
    while (m_stall != STALL - 1 && n < 512) begin
      @(negedge clk_pi);
      n++;
    end
    check_eq("stall_reach", n < 512, 1'b1);
    check_eq("stall_pre", stalled_po, 1'b0);
    clear_pi = 1'b1;
    @(negedge clk_pi);
    clear_pi = 1'b0;
    check_eq("stall_flag", stalled_po, 1'b1);
    check_eq("stall_locked", locked_po, 1'b0);
    check_eq("stall_err_set_wins", error_po, 1'b1);
    check_eq("stall_state", state_po, ST_LOST);

    // edge on the terminal cycle belongs to the closing window
    mon_mode = MON_PULSE;
    wait_valid("bnd_sync");
    pulse_arm = 1'b1;
    wait_valid("bnd_valid1");
    pulse_arm = 1'b0;
    check_eq("bnd_close", edge_count_po, 1);
    wait_valid("bnd_valid2");
    check_eq("bnd_next", edge_count_po, 0);

    // reset mid-window discards the partial window
    mon_mode = MON_25;
    wait_win(500, "rst_mid_reach");
    rst_pi = 1'b1;
    @(negedge clk_pi);
    check_all_zero("rst_mid");
    rst_pi = 1'b0;
    n = 0;
    do begin
      @(negedge clk_pi);
      n++;
    end while (!count_valid_po && n < 3000);
    check_eq("rst_first_window_len", n, WIN);

    // disable returns to IDLE
    en_pi = 1'b0;
    @(negedge clk_pi);
    check_eq("idle_state", state_po, ST_IDLE);
    check_eq("idle_locked", locked_po, 1'b0);
    repeat (4) @(negedge clk_pi);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_freq_monitor.md
CLOCK_FREQ_MONITOR -- requirements
Module: clock_freq_monitor

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1024, clk_pi cycles per measurement window.
REQ-002 Parameter EXPECTED_EDGES, default 256, nominal monitored rising edges per window.
REQ-003 Parameter TOLERANCE, default 4, allowed +/- deviation from EXPECTED_EDGES.
REQ-004 Parameter LOCK_WINDOWS, default 3, consecutive in-range windows required to lock.
REQ-005 Parameter UNLOCK_WINDOWS, default 2, consecutive out-of-range windows required to drop lock.
REQ-006 Parameter STALL_CYCLES, default 64, clk_pi cycles without a monitored edge that mean the clock has stopped.
REQ-007 clk_pi  input  1  free-running trusted measurement clock.
REQ-008 rst_pi  input  1  reset; synchronous to clk_pi, active-high.
REQ-009 en_pi  input  1  enable; low holds the block in IDLE.
REQ-010 mon_pi  input  1  monitored clock (e.g. generated clk_po); asynchronous to clk_pi.
REQ-011 clear_pi  input  1  one-cycle pulse that clears the sticky error flag.
REQ-012 edge_count_po  output  CNT_W  edge count of the last completed window; CNT_W = $clog2(WINDOW_CYCLES+1).
REQ-013 count_valid_po  output  1  one-cycle pulse when edge_count_po updates.
REQ-014 in_range_po  output  1  last completed window was within EXPECTED_EDGES +/- TOLERANCE.
REQ-015 locked_po  output  1  high in LOCKED state.
REQ-016 stalled_po  output  1  no monitored edge for STALL_CYCLES or more cycles.
REQ-017 error_po  output  1  sticky flag; sets on a LOCKED->LOST transition or on stall while LOCKED.

Function
REQ-018 mon_pi shall pass through a 2-flop synchronizer and then a rising-edge detector; a detected edge pulse occurs 3 clk_pi cycles after the sampled 0->1 transition.
REQ-019 The window counter shall run 0..WINDOW_CYCLES-1 while en_pi is high; it wraps to 0 on terminal count without losing a cycle.
REQ-020 An edge pulse on the terminal cycle shall count toward the closing window; the edge counter restarts at 0 on the next cycle, or at 1 if an edge arrives on that cycle.
REQ-021 The edge counter shall saturate at 2^CNT_W-1.
REQ-022 On terminal count, the block shall register edge_count_po, in_range_po and a count_valid_po pulse one cycle later.
REQ-023 in_range_po is true when the count is between EXPECTED_EDGES-TOLERANCE and EXPECTED_EDGES+TOLERANCE, inclusive; the lower bound is clamped at 0.
REQ-024 FSM states: IDLE, ACQUIRE, LOCKED, LOST.
REQ-025 IDLE->ACQUIRE when en_pi is high; any state->IDLE when en_pi is low, which also clears the window, edge, good and bad counters.
REQ-026 ACQUIRE: the good counter increments on each in-range window and clears on an out-of-range window; it goes to LOCKED when the count reaches LOCK_WINDOWS.
REQ-027 LOCKED: the bad counter increments on each out-of-range window and clears on an in-range window; it goes to LOST when the count reaches UNLOCK_WINDOWS.
REQ-028 LOCKED goes to LOST immediately on stalled_po rising.
REQ-029 LOST->ACQUIRE on the next in-range window, with the good counter set to 1.
REQ-030 The stall counter shall increment each cycle with no edge pulse, reset on an edge pulse and saturate; stalled_po = (count >= STALL_CYCLES).
REQ-031 error_po sets per REQ-017 and clears on clear_pi; a set and a clear in the same cycle leave the flag set.
REQ-032 The monitored frequency shall be below clk_pi/2; faster clocks give undefined counts.

Reset
REQ-033 On rst_pi the block shall clear all counters and synchronizer flops, enter state IDLE and drive every output to 0.
REQ-034 Reset mid-window shall discard the partial window; no count_valid_po pulse is generated.

Structure
REQ-035 Package clock_mon_pkg shall hold the FSM state enum and the CNT_W width function.
REQ-036 The synchronizer and edge detector shall be one sub-module, sync_edge_detect.

Verification (clk_pi 100 MHz, defaults)
REQ-037 mon_pi at 25 MHz, en_pi high -> each window counts 255..257, in_range_po=1, locked_po rises at the end of window 3.
REQ-038 Locked, then mon_pi changed to 27 MHz (count ~276) -> in_range_po=0; after 2 windows, locked_po=0 and error_po=1.
REQ-039 Locked, then mon_pi held low -> stalled_po=1 about 64 cycles after the last edge; locked_po=0 and error_po=1 in the same cycle.
REQ-040 Window-boundary edge: an edge pulse forced on the terminal cycle is counted in the closing window, and the next window starts counting at 0.
REQ-041 rst_pi asserted at window cycle 500 -> all outputs 0 next cycle, no count_valid_po, and the first window after release is a full 1024 cycles.
REQ-042 error_po set, then clear_pi pulsed -> error_po=0 next cycle; clear_pi coinciding with a new error leaves error_po=1.
